// File: rtl/l1i_miss_handler.sv
// L1 instruction-cache miss handler: merges same-line misses, issues one L2 read per line,
// then installs the returning line through a two-stage fill pipeline and wakes waiting threads.
module l1i_miss_handler #(
    parameter int NUM_ENTRIES = 4,
    parameter int NUM_WAYS    = 4,
    parameter int SET_BITS    = 6,
    localparam int ID_W       = $clog2(NUM_ENTRIES),
    localparam int WAY_W      = $clog2(NUM_WAYS),
    localparam int TAG_BITS   = 26 - SET_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ifd_cache_miss,
    input  logic [25:0]            ifd_cache_miss_addr,
    input  logic [ID_W-1:0]        ifd_cache_miss_thread_idx,
    output logic                   l2i_icache_lru_fill_en,
    output logic [SET_BITS-1:0]    l2i_icache_lru_fill_set,
    input  logic [WAY_W-1:0]       ift_fill_lru,
    output logic [NUM_WAYS-1:0]    l2i_itag_update_en_oh,
    output logic [SET_BITS-1:0]    l2i_itag_update_set,
    output logic [TAG_BITS-1:0]    l2i_itag_update_tag,
    output logic                   l2i_itag_update_valid,
    output logic                   l2i_idata_update_en,
    output logic [WAY_W-1:0]       l2i_idata_update_way,
    output logic [SET_BITS-1:0]    l2i_idata_update_set,
    output logic [511:0]           l2i_idata_update_data,
    output logic [NUM_ENTRIES-1:0] l2i_icache_wake_bitmap,
    output logic                   l2i_request_valid,
    input  logic                   l2i_request_ready,
    output logic [ID_W-1:0]        l2i_request_id,
    output logic [25:0]            l2i_request_addr,
    input  logic                   l2_response_valid,
    input  logic [ID_W-1:0]        l2_response_id,
    input  logic [511:0]           l2_response_data
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SEND = 2'd1, WAIT_RESP = 2'd2} entry_state_t;

    entry_state_t           state_r     [NUM_ENTRIES];
    logic [25:0]            line_addr_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] waiters_r   [NUM_ENTRIES];

    logic                   request_valid_r;
    logic [ID_W-1:0]        request_id_r;
    logic [25:0]            request_addr_r;
    logic [ID_W-1:0]        rr_r;

    logic                   f2_valid_r;
    logic [ID_W-1:0]        f2_id_r;
    logic [SET_BITS-1:0]    f2_set_r;
    logic [TAG_BITS-1:0]    f2_tag_r;
    logic [511:0]           f2_data_r;

    logic [NUM_ENTRIES-1:0] match_oh_s;
    logic [NUM_ENTRIES-1:0] merge_oh_s;
    logic [NUM_ENTRIES-1:0] alloc_oh_s;
    logic [NUM_ENTRIES-1:0] thread_oh_s;
    logic [NUM_ENTRIES-1:0] pend_s;
    logic                   free_any_s;
    logic [ID_W-1:0]        free_idx_s;
    logic                   pick_found_s;
    logic [ID_W-1:0]        pick_s;
    logic [ID_W-1:0]        scan_idx_s;
    logic                   f2_hit_s;
    logic                   resp_ok_s;

    // Miss lookup: line match against live entries and lowest-index free entry.
    always_comb begin
        match_oh_s  = {NUM_ENTRIES{1'b0}};
        free_any_s  = 1'b0;
        free_idx_s  = {ID_W{1'b0}};
        thread_oh_s = NUM_ENTRIES'(1) << ifd_cache_miss_thread_idx;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state_r[i] != IDLE && line_addr_r[i] == ifd_cache_miss_addr) begin
                match_oh_s[i] = 1'b1;
            end else begin
                match_oh_s[i] = 1'b0;
            end
            if (!free_any_s && state_r[i] == IDLE) begin
                free_any_s = 1'b1;
                free_idx_s = ID_W'(i);
            end else begin
                free_any_s = free_any_s;
            end
        end
        merge_oh_s = ifd_cache_miss ? match_oh_s : {NUM_ENTRIES{1'b0}};
        if (ifd_cache_miss && match_oh_s == {NUM_ENTRIES{1'b0}} && free_any_s) begin
            alloc_oh_s = NUM_ENTRIES'(1) << free_idx_s;
        end else begin
            alloc_oh_s = {NUM_ENTRIES{1'b0}};
        end
        f2_hit_s  = ifd_cache_miss && f2_valid_r && match_oh_s[f2_id_r];
        resp_ok_s = state_r[l2_response_id] == WAIT_RESP && !(f2_valid_r && f2_id_r == l2_response_id);
    end

    // Round-robin pick among entries still waiting to send; the presented entry is excluded
    // and a miss allocating this cycle is eligible so it can be requested the next cycle.
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = rr_r;
        scan_idx_s   = rr_r;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            pend_s[i] = (state_r[i] == WAIT_SEND && !(request_valid_r && request_id_r == ID_W'(i)))
                        || alloc_oh_s[i];
        end
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            scan_idx_s = rr_r + ID_W'(k);
            if (!pick_found_s && pend_s[scan_idx_s]) begin
                pick_found_s = 1'b1;
                pick_s       = scan_idx_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Entry state machines, request register and fill pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_r[i]     <= IDLE;
                line_addr_r[i] <= 26'd0;
                waiters_r[i]   <= {NUM_ENTRIES{1'b0}};
            end
            request_valid_r <= 1'b0;
            request_id_r    <= {ID_W{1'b0}};
            request_addr_r  <= 26'd0;
            rr_r            <= {ID_W{1'b0}};
            f2_valid_r      <= 1'b0;
            f2_id_r         <= {ID_W{1'b0}};
            f2_set_r        <= {SET_BITS{1'b0}};
            f2_tag_r        <= {TAG_BITS{1'b0}};
            f2_data_r       <= 512'd0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                case (state_r[i])
                    IDLE: begin
                        if (alloc_oh_s[i]) begin
                            state_r[i]     <= WAIT_SEND;
                            line_addr_r[i] <= ifd_cache_miss_addr;
                            waiters_r[i]   <= thread_oh_s;
                        end
                    end
                    WAIT_SEND: begin
                        if (request_valid_r && l2i_request_ready && request_id_r == ID_W'(i)) begin
                            state_r[i] <= WAIT_RESP;
                        end
                        if (merge_oh_s[i]) begin
                            waiters_r[i] <= waiters_r[i] | thread_oh_s;
                        end
                    end
                    WAIT_RESP: begin
                        // A miss on the line being installed is woken directly, not merged.
                        if (f2_valid_r && f2_id_r == ID_W'(i)) begin
                            state_r[i]   <= IDLE;
                            waiters_r[i] <= {NUM_ENTRIES{1'b0}};
                        end else if (merge_oh_s[i]) begin
                            waiters_r[i] <= waiters_r[i] | thread_oh_s;
                        end
                    end
                    default: state_r[i] <= IDLE;
                endcase
            end

            if (!request_valid_r || l2i_request_ready) begin
                request_valid_r <= pick_found_s;
                if (pick_found_s) begin
                    request_id_r   <= pick_s;
                    request_addr_r <= alloc_oh_s[pick_s] ? ifd_cache_miss_addr : line_addr_r[pick_s];
                    rr_r           <= pick_s + ID_W'(1);
                end
            end

            f2_valid_r <= l2_response_valid;
            if (l2_response_valid) begin
                f2_id_r   <= l2_response_id;
                f2_set_r  <= line_addr_r[l2_response_id][SET_BITS-1:0];
                f2_tag_r  <= line_addr_r[l2_response_id][25:SET_BITS];
                f2_data_r <= l2_response_data;
            end
        end
    end

    // Victim query rides the response cycle; the way only arrives in F2, so tag/data enables follow it.
    assign l2i_icache_lru_fill_en  = l2_response_valid & ~reset;
    assign l2i_icache_lru_fill_set = l2i_icache_lru_fill_en ? line_addr_r[l2_response_id][SET_BITS-1:0]
                                                            : {SET_BITS{1'b0}};
    assign l2i_itag_update_en_oh   = f2_valid_r ? (NUM_WAYS'(1) << ift_fill_lru) : {NUM_WAYS{1'b0}};
    assign l2i_itag_update_set     = f2_set_r;
    assign l2i_itag_update_tag     = f2_tag_r;
    assign l2i_itag_update_valid   = f2_valid_r;
    assign l2i_idata_update_en     = f2_valid_r;
    assign l2i_idata_update_way    = f2_valid_r ? ift_fill_lru : {WAY_W{1'b0}};
    assign l2i_idata_update_set    = f2_set_r;
    assign l2i_idata_update_data   = f2_data_r;
    assign l2i_icache_wake_bitmap  = f2_valid_r ? (waiters_r[f2_id_r] | (f2_hit_s ? thread_oh_s : {NUM_ENTRIES{1'b0}}))
                                                : {NUM_ENTRIES{1'b0}};
    assign l2i_request_valid       = request_valid_r;
    assign l2i_request_id          = request_id_r;
    assign l2i_request_addr        = request_addr_r;

    l1i_miss_handler_chk u_chk (
        .clk            (clk),
        .reset          (reset),
        .miss_needs_new (ifd_cache_miss && match_oh_s == {NUM_ENTRIES{1'b0}}),
        .free_any       (free_any_s),
        .resp_valid     (l2_response_valid),
        .resp_ok        (resp_ok_s)
    );
endmodule

// Protocol checks: a new miss always finds a free entry; responses only target entries awaiting one.
module l1i_miss_handler_chk (
    input logic clk,
    input logic reset,
    input logic miss_needs_new,
    input logic free_any,
    input logic resp_valid,
    input logic resp_ok
);
    // Sampled on the active edge outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(miss_needs_new && !free_any)) else $error("miss with no free entry");
            assert (!(resp_valid && !resp_ok)) else $error("response for entry not awaiting one");
        end
    end
endmodule

// File: tb/tb_l1i_miss_handler.sv
// Self-checking bench for l1i_miss_handler: scoreboard queues for requests and fills plus a vector table.
module tb_l1i_miss_handler;
    logic         clk = 1'b0;
    logic         reset;
    logic         ifd_cache_miss;
    logic [25:0]  ifd_cache_miss_addr;
    logic [1:0]   ifd_cache_miss_thread_idx;
    logic         l2i_icache_lru_fill_en;
    logic [5:0]   l2i_icache_lru_fill_set;
    logic [1:0]   ift_fill_lru;
    logic [3:0]   l2i_itag_update_en_oh;
    logic [5:0]   l2i_itag_update_set;
    logic [19:0]  l2i_itag_update_tag;
    logic         l2i_itag_update_valid;
    logic         l2i_idata_update_en;
    logic [1:0]   l2i_idata_update_way;
    logic [5:0]   l2i_idata_update_set;
    logic [511:0] l2i_idata_update_data;
    logic [3:0]   l2i_icache_wake_bitmap;
    logic         l2i_request_valid;
    logic         l2i_request_ready;
    logic [1:0]   l2i_request_id;
    logic [25:0]  l2i_request_addr;
    logic         l2_response_valid;
    logic [1:0]   l2_response_id;
    logic [511:0] l2_response_data;

    always #5 clk = ~clk;

    l1i_miss_handler dut (
        .clk                       (clk),
        .reset                     (reset),
        .ifd_cache_miss            (ifd_cache_miss),
        .ifd_cache_miss_addr       (ifd_cache_miss_addr),
        .ifd_cache_miss_thread_idx (ifd_cache_miss_thread_idx),
        .l2i_icache_lru_fill_en    (l2i_icache_lru_fill_en),
        .l2i_icache_lru_fill_set   (l2i_icache_lru_fill_set),
        .ift_fill_lru              (ift_fill_lru),
        .l2i_itag_update_en_oh     (l2i_itag_update_en_oh),
        .l2i_itag_update_set       (l2i_itag_update_set),
        .l2i_itag_update_tag       (l2i_itag_update_tag),
        .l2i_itag_update_valid     (l2i_itag_update_valid),
        .l2i_idata_update_en       (l2i_idata_update_en),
        .l2i_idata_update_way      (l2i_idata_update_way),
        .l2i_idata_update_set      (l2i_idata_update_set),
        .l2i_idata_update_data     (l2i_idata_update_data),
        .l2i_icache_wake_bitmap    (l2i_icache_wake_bitmap),
        .l2i_request_valid         (l2i_request_valid),
        .l2i_request_ready         (l2i_request_ready),
        .l2i_request_id            (l2i_request_id),
        .l2i_request_addr          (l2i_request_addr),
        .l2_response_valid         (l2_response_valid),
        .l2_response_id            (l2_response_id),
        .l2_response_data          (l2_response_data)
    );

    typedef struct {
        logic [1:0]  id;
        logic [25:0] addr;
    } req_t;

    typedef struct {
        logic [5:0]   set;
        logic [19:0]  tag;
        logic [1:0]   way;
        logic [3:0]   onehot;
        logic [3:0]   wake;
        logic [511:0] data;
    } fill_t;

    typedef struct {
        logic [1:0]  thread;
        logic [25:0] addr;
        logic [1:0]  exp_id;
        logic [1:0]  way;
        logic [3:0]  exp_onehot;
        logic [5:0]  exp_set;
        logic [19:0] exp_tag;
        logic [3:0]  exp_wake;
    } vec_t;

    req_t  exp_req[$];
    fill_t exp_fill[$];
    req_t  mon_req;
    fill_t mon_fill;
    vec_t  tbl[4];
    int    order[4];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    seq      = 0;
    logic [1:0] pend_way = 2'd0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: request handshakes and fills are popped and compared mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (l2i_request_valid && l2i_request_ready) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_request: got id %0d addr %0h expected none",
                             l2i_request_id, l2i_request_addr);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("req_id", 512'(l2i_request_id), 512'(mon_req.id));
                    chk("req_addr", 512'(l2i_request_addr), 512'(mon_req.addr));
                end
            end
            if (l2i_idata_update_en) begin
                if (exp_fill.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_fill: got set %0h wake %0h expected none",
                             l2i_idata_update_set, l2i_icache_wake_bitmap);
                end else begin
                    mon_fill = exp_fill.pop_front();
                    chk("itag_set", 512'(l2i_itag_update_set), 512'(mon_fill.set));
                    chk("idata_set", 512'(l2i_idata_update_set), 512'(mon_fill.set));
                    chk("itag_tag", 512'(l2i_itag_update_tag), 512'(mon_fill.tag));
                    chk("itag_valid", 512'(l2i_itag_update_valid), 512'(1'b1));
                    chk("itag_en_oh", 512'(l2i_itag_update_en_oh), 512'(mon_fill.onehot));
                    chk("idata_way", 512'(l2i_idata_update_way), 512'(mon_fill.way));
                    chk("idata_data", l2i_idata_update_data, mon_fill.data);
                    chk("wake_bitmap", 512'(l2i_icache_wake_bitmap), 512'(mon_fill.wake));
                end
            end else if (l2i_itag_update_en_oh != 4'd0 || l2i_icache_wake_bitmap != 4'd0) begin
                n_checks++;
                n_fails++;
                $display("FAIL stray_fill: got en_oh %0h wake %0h expected 0",
                         l2i_itag_update_en_oh, l2i_icache_wake_bitmap);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        ifd_cache_miss    = 1'b0;
        l2_response_valid = 1'b0;
        ift_fill_lru      = pend_way;
    endtask

    task automatic miss(input logic [1:0] thread, input logic [25:0] addr);
        cyc();
        ifd_cache_miss            = 1'b1;
        ifd_cache_miss_thread_idx = thread;
        ifd_cache_miss_addr       = addr;
    endtask

    task automatic push_req(input logic [1:0] id, input logic [25:0] addr);
        req_t r;
        r.id   = id;
        r.addr = addr;
        exp_req.push_back(r);
    endtask

    task automatic respond(input logic [1:0] id, input logic [1:0] way, input logic [3:0] onehot,
                           input logic [5:0] set, input logic [19:0] tag, input logic [3:0] wake);
        fill_t f;
        logic [511:0] d;
        d = {16{32'hD00D0000 + 32'(seq)}};
        seq++;
        cyc();
        l2_response_valid = 1'b1;
        l2_response_id    = id;
        l2_response_data  = d;
        pend_way          = way;
        f.set    = set;
        f.tag    = tag;
        f.way    = way;
        f.onehot = onehot;
        f.wake   = wake;
        f.data   = d;
        exp_fill.push_back(f);
        @(negedge clk);
        chk("lru_fill_en", 512'(l2i_icache_lru_fill_en), 512'(1'b1));
        chk("lru_fill_set", 512'(l2i_icache_lru_fill_set), 512'(set));
    endtask

    task automatic wait_reqs();
        int n = 0;
        while (exp_req.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        if (exp_req.size() != 0) begin
            chk("req_timeout", 512'(exp_req.size()), 512'd0);
            exp_req.delete();
        end
    endtask

    initial begin
        tbl[0] = '{2'd0, 26'h000101, 2'd0, 2'd0, 4'b0001, 6'h01, 20'h00004, 4'b0001};
        tbl[1] = '{2'd1, 26'h000202, 2'd1, 2'd1, 4'b0010, 6'h02, 20'h00008, 4'b0010};
        tbl[2] = '{2'd2, 26'h000303, 2'd2, 2'd3, 4'b1000, 6'h03, 20'h0000C, 4'b0100};
        tbl[3] = '{2'd3, 26'h000404, 2'd3, 2'd2, 4'b0100, 6'h04, 20'h00010, 4'b1000};
        order  = '{2, 0, 3, 1};

        reset                     = 1'b1;
        ifd_cache_miss            = 1'b0;
        ifd_cache_miss_addr       = 26'd0;
        ifd_cache_miss_thread_idx = 2'd0;
        ift_fill_lru              = 2'd0;
        l2i_request_ready         = 1'b1;
        l2_response_valid         = 1'b0;
        l2_response_id            = 2'd0;
        l2_response_data          = 512'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_request_valid", 512'(l2i_request_valid), 512'd0);
        chk("rst_lru_fill_en", 512'(l2i_icache_lru_fill_en), 512'd0);
        chk("rst_itag_en_oh", 512'(l2i_itag_update_en_oh), 512'd0);
        chk("rst_idata_en", 512'(l2i_idata_update_en), 512'd0);
        chk("rst_wake", 512'(l2i_icache_wake_bitmap), 512'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // Single miss, one-cycle request latency, response two cycles after the request.
        miss(2'd0, 26'h000100);
        push_req(2'd0, 26'h000100);
        cyc();
        @(negedge clk);
        chk("req_latency", 512'(l2i_request_valid), 512'd1);
        cyc();
        cyc();
        respond(2'd0, 2'd2, 4'b0100, 6'h00, 20'h00004, 4'b0001);
        cyc();
        cyc();

        // Merge of two threads; the second miss coincides with the request handshake.
        miss(2'd1, 26'h000200);
        push_req(2'd0, 26'h000200);
        miss(2'd3, 26'h000200);
        wait_reqs();
        repeat (3) cyc();
        respond(2'd0, 2'd1, 4'b0010, 6'h00, 20'h00008, 4'b1010);
        cyc();
        cyc();

        // Backpressure: request must hold steady while ready is low.
        l2i_request_ready = 1'b0;
        miss(2'd0, 26'h000040);
        push_req(2'd0, 26'h000040);
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            chk("bp_valid", 512'(l2i_request_valid), 512'd1);
            chk("bp_id", 512'(l2i_request_id), 512'd0);
            chk("bp_addr", 512'(l2i_request_addr), 512'h40);
        end
        cyc();
        l2i_request_ready = 1'b1;
        wait_reqs();
        respond(2'd0, 2'd3, 4'b1000, 6'h00, 20'h00001, 4'b0001);
        cyc();
        cyc();

        // Four distinct misses from the table, filled back-to-back out of order.
        for (int i = 0; i < 4; i++) begin
            miss(tbl[i].thread, tbl[i].addr);
            push_req(tbl[i].exp_id, tbl[i].addr);
        end
        wait_reqs();
        cyc();
        for (int k = 0; k < 4; k++) begin
            respond(tbl[order[k]].exp_id, tbl[order[k]].way, tbl[order[k]].exp_onehot,
                    tbl[order[k]].exp_set, tbl[order[k]].exp_tag, tbl[order[k]].exp_wake);
        end
        cyc();
        cyc();

        // Race: a miss on the line during its F2 cycle is woken immediately, no new request.
        miss(2'd0, 26'h000300);
        push_req(2'd0, 26'h000300);
        wait_reqs();
        cyc();
        respond(2'd0, 2'd0, 4'b0001, 6'h00, 20'h0000C, 4'b0101);
        miss(2'd2, 26'h000300);
        repeat (5) cyc();

        // Reset during F1 discards the fill and empties all entries.
        miss(2'd1, 26'h000500);
        push_req(2'd0, 26'h000500);
        wait_reqs();
        cyc();
        reset             = 1'b1;
        l2_response_valid = 1'b1;
        l2_response_id    = 2'd0;
        l2_response_data  = {16{32'hBAD0BAD0}};
        @(negedge clk);
        chk("rstf1_lru_fill_en", 512'(l2i_icache_lru_fill_en), 512'd0);
        chk("rstf1_request_valid", 512'(l2i_request_valid), 512'd0);
        chk("rstf1_idata_en", 512'(l2i_idata_update_en), 512'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rstf2_idata_en", 512'(l2i_idata_update_en), 512'd0);
        chk("rstf2_itag_en_oh", 512'(l2i_itag_update_en_oh), 512'd0);
        chk("rstf2_wake", 512'(l2i_icache_wake_bitmap), 512'd0);
        chk("rstf2_request_valid", 512'(l2i_request_valid), 512'd0);
        miss(2'd2, 26'h000500);
        push_req(2'd0, 26'h000500);
        wait_reqs();
        respond(2'd0, 2'd1, 4'b0010, 6'h00, 20'h00014, 4'b0100);
        repeat (4) cyc();

        chk("req_queue_drained", 512'(exp_req.size()), 512'd0);
        chk("fill_queue_drained", 512'(exp_fill.size()), 512'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
